// File: rtl/mds_folded.sv
// Twofish MDS column multiply over GF(2^8), folded to ROWS_PER_CYCLE rows per clock.
// Valid/ready on both sides; the result register is written row by row while in CALC.
module mds_folded #(
    parameter int         ROWS_PER_CYCLE = 4,
    parameter logic [8:0] POLY           = 9'h169
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  y0,
    input  logic [7:0]  y1,
    input  logic [7:0]  y2,
    input  logic [7:0]  y3,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out
);

    generate
        if (!(ROWS_PER_CYCLE == 1 || ROWS_PER_CYCLE == 2 || ROWS_PER_CYCLE == 4)) begin : g_bad_rows
            $error("mds_folded: ROWS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam int         R  = ROWS_PER_CYCLE;
    localparam logic [2:0] R3 = 3'(ROWS_PER_CYCLE);

    // Row-major: entry {row, col}.
    localparam logic [0:15][7:0] MDS = {
        8'h01, 8'hEF, 8'h5B, 8'h5B,
        8'h5B, 8'hEF, 8'hEF, 8'h01,
        8'hEF, 8'h5B, 8'h01, 8'hEF,
        8'hEF, 8'h01, 8'hEF, 8'h5B
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ sh;
            end
            sh = sh[7] ? ({sh[6:0], 1'b0} ^ POLY[7:0]) : {sh[6:0], 1'b0};
        end
        return acc;
    endfunction

    state_t     state_q, state_d;
    logic [1:0] rc_q, rc_d;
    logic [7:0] col_q [4];
    logic [7:0] col_d [4];
    logic [7:0] res_q [4];
    logic [7:0] res_d [4];
    logic       in_ready_q, in_ready_d;
    logic       out_valid_q, out_valid_d;

    logic [1:0] row_idx [R];
    logic [7:0] row_val [R];
    logic [2:0] rc_sum;

    generate
        for (genvar gi = 0; gi < R; gi++) begin : g_row
            logic [7:0] prod [4];
            assign row_idx[gi] = rc_q + 2'(gi);
            for (genvar gj = 0; gj < 4; gj++) begin : g_col
                assign prod[gj] = gf_mul(MDS[{row_idx[gi], 2'(gj)}], col_q[gj]);
            end
            assign row_val[gi] = prod[0] ^ prod[1] ^ prod[2] ^ prod[3];
        end
    endgenerate

    // Carry out of the 2-bit counter marks the cycle that writes row 3.
    assign rc_sum = {1'b0, rc_q} + R3;

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        col_d   = col_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    col_d   = '{y0, y1, y2, y3};
                    rc_d    = 2'd0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                for (int k = 0; k < R; k++) begin
                    res_d[row_idx[k]] = row_val[k];
                end
                rc_d = rc_sum[1:0];
                if (rc_sum[2]) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rc_q        <= 2'd0;
            col_q       <= '{default: 8'h00};
            res_q       <= '{default: 8'h00};
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rc_q        <= rc_d;
            col_q       <= col_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = {res_q[0], res_q[1], res_q[2], res_q[3]};

endmodule

// File: tb/tb_mds_folded.sv
// Scoreboard bench for mds_folded: one instance per legal ROWS_PER_CYCLE, each with
// its own driver and monitor, all checked against a plain-arithmetic GF(2^8) model.
module tb_mds_folded;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int mds_ref [4][4] = '{
        '{'h01, 'hEF, 'h5B, 'h5B},
        '{'h5B, 'hEF, 'hEF, 'h01},
        '{'hEF, 'h5B, 'h01, 'hEF},
        '{'hEF, 'h01, 'hEF, 'h5B}
    };

    // Carry-less product, then long-division style reduction by 0x169.
    function automatic int ref_mul(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int i = 14; i >= 8; i--) if (((p >> i) & 1) != 0) p = p ^ ('h169 << (i - 8));
        return p;
    endfunction

    function automatic logic [31:0] ref_mds(input logic [31:0] col);
        logic [31:0] r;
        int z;
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            z = 0;
            for (int j = 0; j < 4; j++) z = z ^ ref_mul(mds_ref[i][j], int'((col >> (24 - 8 * j)) & 32'hFF));
            r = (r << 8) | 32'(z & 'hFF);
        end
        return r;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_r
        localparam int R   = 1 << gi;
        localparam int LAT = 4 / R + 1;
        localparam int PER = 4 / R + 2;

        logic        rst, in_valid, in_ready, out_valid, out_ready;
        logic [7:0]  y0, y1, y2, y3;
        logic [31:0] out;

        mds_folded #(.ROWS_PER_CYCLE(R), .POLY(9'h169)) dut (
            .clk(clk), .rst(rst),
            .in_valid(in_valid), .in_ready(in_ready),
            .y0(y0), .y1(y1), .y2(y2), .y3(y3),
            .out_valid(out_valid), .out_ready(out_ready), .out(out)
        );

        logic [31:0] exp_q [$];
        int          acc_q [$];
        bit          done = 1'b0;
        bit          b2b  = 1'b0;
        bit          prev_hold = 1'b0;
        int          last_xfer = -1;
        int          xfers = 0;
        logic [31:0] last_out = 32'h0;
        logic [31:0] prev_out = 32'h0;

        // Monitor: records accepts into the scoreboard, checks every presented result.
        always @(negedge clk) begin
            if (rst) begin
                exp_q.delete();
                acc_q.delete();
                prev_hold = 1'b0;
            end else begin
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_mds({y0, y1, y2, y3}));
                    acc_q.push_back(cyc + 1);
                end
                if (out_valid) begin
                    chk(in_ready == 1'b0, $sformatf("R%0d in_ready_in_done", R), 32'(in_ready), 32'h0);
                    if (prev_hold) begin
                        chk(out == prev_out, $sformatf("R%0d out_stable", R), out, prev_out);
                    end else if (acc_q.size() == 0) begin
                        chk(1'b0, $sformatf("R%0d unexpected_out", R), out, 32'h0);
                    end else begin
                        chk(cyc - acc_q[0] + 1 == LAT, $sformatf("R%0d latency", R), 32'(cyc - acc_q[0] + 1), 32'(LAT));
                    end
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            chk(1'b0, $sformatf("R%0d unexpected_xfer", R), out, 32'h0);
                        end else begin
                            chk(out == exp_q[0], $sformatf("R%0d result", R), out, exp_q[0]);
                            void'(exp_q.pop_front());
                            void'(acc_q.pop_front());
                        end
                        if (b2b && last_xfer >= 0)
                            chk(cyc - last_xfer == PER, $sformatf("R%0d period", R), 32'(cyc - last_xfer), 32'(PER));
                        last_xfer = cyc;
                        last_out  = out;
                        xfers++;
                    end
                end
                prev_hold = out_valid && !out_ready;
                prev_out  = out;
            end
            if (!b2b) last_xfer = -1;
        end

        task automatic send(input logic [31:0] c);
            int g;
            g = 0;
            {y0, y1, y2, y3} = c;
            in_valid = 1'b1;
            @(negedge clk);
            while (!in_ready && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (g >= 50) chk(1'b0, $sformatf("R%0d accept_timeout", R), 32'(g), 32'd50);
            @(posedge clk);
            #1 in_valid = 1'b0;
        endtask

        task automatic drain();
            int g;
            g = 0;
            while ((exp_q.size() != 0 || out_valid) && g < 100) begin
                @(posedge clk);
                #1 g++;
            end
            if (g >= 100) chk(1'b0, $sformatf("R%0d drain_timeout", R), 32'(g), 32'd100);
        endtask

        task automatic check_reset_state(input string tag);
            @(negedge clk);
            chk(out_valid == 1'b0, $sformatf("R%0d %s out_valid", R, tag), 32'(out_valid), 32'h0);
            chk(in_ready == 1'b1, $sformatf("R%0d %s in_ready", R, tag), 32'(in_ready), 32'h1);
            chk(out == 32'h0, $sformatf("R%0d %s out", R, tag), out, 32'h0);
        endtask

        task automatic pulse_reset(input string tag);
            rst = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            check_reset_state(tag);
            @(posedge clk);
            #1;
        endtask

        logic [31:0] dir_col [6] = '{32'h01000000, 32'h00010000, 32'h00000001,
                                     32'h01010000, 32'h02000000, 32'h00000000};
        logic [31:0] dir_exp [6] = '{32'h015BEFEF, 32'hEFEF5B01, 32'h5B01EF5B,
                                     32'hEEB4B4EE, 32'h02B6B7B7, 32'h00000000};

        initial begin : driver
            int n, g, x0;
            rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
            {y0, y1, y2, y3} = 32'h0;
            repeat (2) @(posedge clk);
            check_reset_state("reset");
            @(posedge clk);
            #1 rst = 1'b0;

            out_ready = 1'b1;
            for (int k = 0; k < 6; k++) begin
                send(dir_col[k]);
                drain();
                chk(last_out == dir_exp[k], $sformatf("R%0d vector%0d", R, k), last_out, dir_exp[k]);
            end

            // Backpressure: result must hold while out_ready stays low and inputs churn.
            out_ready = 1'b0;
            send($urandom);
            g = 0;
            while (!out_valid && g < 50) begin
                @(posedge clk);
                #1 g++;
            end
            repeat (10) begin
                @(posedge clk);
                #1 in_valid = 1'($urandom);
                {y0, y1, y2, y3} = $urandom;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk(in_ready == 1'b1, $sformatf("R%0d ready_after_xfer", R), 32'(in_ready), 32'h1);
            @(posedge clk);
            #1 drain();

            b2b = 1'b1;
            x0 = xfers;
            n = 0;
            g = 0;
            in_valid = 1'b1;
            {y0, y1, y2, y3} = $urandom;
            while (n < 8 && g < 200) begin
                @(negedge clk);
                if (in_ready) n++;
                @(posedge clk);
                #1 {y0, y1, y2, y3} = $urandom;
                g++;
            end
            in_valid = 1'b0;
            drain();
            chk(xfers - x0 == 8, $sformatf("R%0d b2b_count", R), 32'(xfers - x0), 32'd8);
            b2b = 1'b0;

            out_ready = 1'b0;
            send($urandom);
            @(posedge clk);
            #1 pulse_reset("reset_mid_op");

            send($urandom);
            g = 0;
            while (!out_valid && g < 50) begin
                @(posedge clk);
                #1 g++;
            end
            repeat (2) @(posedge clk);
            #1 pulse_reset("reset_in_done");

            out_ready = 1'b1;
            x0 = xfers;
            send($urandom);
            drain();
            chk(xfers - x0 == 1, $sformatf("R%0d fresh_after_reset", R), 32'(xfers - x0), 32'd1);
            done = 1'b1;
        end
    end

    initial begin : supervisor
        int t;
        t = 0;
        while (!(g_r[0].done && g_r[1].done && g_r[2].done) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 20000) chk(1'b0, "global_timeout", 32'(t), 32'd20000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mds_folded.md
# mds_folded

Parametrised, sequential successor to the combinational Twofish MDS multiplier. It multiplies a 4-byte column (y0..y3) by the Twofish 4x4 MDS matrix over GF(2^8). It evaluates ROWS_PER_CYCLE matrix rows per clock, so area can be traded against latency. It sits between the q-permutation/key-dependent S-box stage and the PHT in the g-function, and uses valid/ready handshakes on both sides so the round controller can stall it.

## Interface
- ROWS_PER_CYCLE, 4: matrix rows evaluated per clock; legal values 1, 2, 4; any other value must fail elaboration.
- POLY, 9'h169: GF(2^8) reduction polynomial, including the x^8 term.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  y0..y3 valid.
- in_ready  output  1  block can accept a column.
- y0, y1, y2, y3  input  8 each  input column bytes.
- out_valid  output  1  out holds a finished result.
- out_ready  input  1  downstream accepts out.
- out  output  32  result {z0,z1,z2,z3}, with z0 (row 0) in bits [31:24].

## Operation
- Matrix, rows top to bottom, columns multiply y0..y3:
  - row 0: 01 EF 5B 5B
  - row 1: 5B EF EF 01
  - row 2: EF 5B 01 EF
  - row 3: EF 01 EF 5B
- zi = XOR over j of gfmul(M[i][j], yj), with products reduced modulo POLY.
- Hardware uses 4*ROWS_PER_CYCLE gf multipliers; coefficients are constants selected by the row counter.
- States:
  - IDLE: in_ready=1.
    - On in_valid: latch y0..y3, clear row counter rc, go to CALC.
  - CALC: each cycle compute rows rc..rc+ROWS_PER_CYCLE-1 from the latched column and write them into the result register bytes; rc += ROWS_PER_CYCLE.
    - When this cycle's write covers row 3, go to DONE.
    - rc width is 2 bits and wraps to 0; it is never used as a wrapped value.
  - DONE: out_valid=1; out is stable.
    - On out_ready: go to IDLE.
- in_ready is 1 only in IDLE. Inputs presented in CALC or DONE are ignored, and the latched column must not change.
- out bytes not yet written in the current operation hold their previous values. Only DONE qualifies out.
- in_valid and y0..y3 may change freely while in_ready=0.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, out=32'h0, rc=0, latched column=0.
- Latency: accept edge to first cycle with out_valid=1 is 4/ROWS_PER_CYCLE + 1 clocks (2, 3 or 5 for R=4, 2, 1).
- Throughput with out_ready held at 1: one column per 4/ROWS_PER_CYCLE + 2 clocks (IDLE, CALC..., DONE).
- out_valid and out_ready high in the same cycle: transfer completes, and IDLE (in_ready=1) follows on the next clock.
- out_valid stays high and out holds its value for any number of cycles while out_ready=0.
- rst asserted in any state, including mid-CALC or DONE with out_ready=0: all reset values apply on the next edge and the in-flight result is discarded. rst takes priority over every handshake in the same cycle.
- There is no combinational path from in_valid/y* to out, or from out_ready to in_ready.

## Test plan
- Unit vectors, all three ROWS_PER_CYCLE values:
  - y=(01,00,00,00) -> out=32'h015BEFEF
  - y=(00,01,00,00) -> out=32'hEFEF5B01
  - y=(00,00,00,01) -> out=32'h5B01EF5B
- Each result must appear with exactly the specified latency.
- Linearity and reduction:
  - y=(01,01,00,00) -> 32'hEEB4B4EE
  - y=(02,00,00,00) -> 32'h02B6B7B7 (EF*02 needs reduction by 0x169)
  - y=(00,00,00,00) -> 32'h00000000
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. out_valid stays 1, out is unchanged, in_ready=0, and toggling y*/in_valid has no effect. Raise out_ready: next cycle in_ready=1.
- Back-to-back: in_valid and out_ready held high with 8 random columns. Every output matches a software MDS model, in order, with one result per 4/R+2 cycles.
- Reset mid-CALC (R=1, two cycles after accept) and reset in DONE: the next cycle shows out_valid=0, in_ready=1, out=0. A fresh column then completes correctly.
- Illegal ROWS_PER_CYCLE=3 causes an elaboration failure.
